// File: rtl/mem_bank_2rw_mask_param_if.sv
// Request/response bundle for the two-port masked memory bank.
//
// Per port x in {0,1}:
//   RWx_en     request valid
//   RWx_wmode  1 = write, 0 = read
//   RWx_addr   word address
//   RWx_wmask  lane write enables, lane j covers bits [j*MASK_GRAN +: MASK_GRAN]
//   RWx_wdata  write data
//   RWx_rdata  registered read data, held until the next read completes
//   RWx_rvalid one-cycle pulse, read data valid
// Bank status:
//   init_done  high once the post-reset clear sweep has finished
//   collision  one-cycle pulse on an overlapping same-address dual write
//
// master: the requester. slave: the bank.
interface mem_bank_2rw_mask_param_if #(
   parameter int unsigned DATA_W    = 80,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned MASK_GRAN = 8
);
   localparam int unsigned MASK_W = DATA_W / MASK_GRAN;

   logic              init_done;
   logic              collision;

   logic              RW0_en;
   logic              RW0_wmode;
   logic [ADDR_W-1:0] RW0_addr;
   logic [MASK_W-1:0] RW0_wmask;
   logic [DATA_W-1:0] RW0_wdata;
   logic [DATA_W-1:0] RW0_rdata;
   logic              RW0_rvalid;

   logic              RW1_en;
   logic              RW1_wmode;
   logic [ADDR_W-1:0] RW1_addr;
   logic [MASK_W-1:0] RW1_wmask;
   logic [DATA_W-1:0] RW1_wdata;
   logic [DATA_W-1:0] RW1_rdata;
   logic              RW1_rvalid;

   modport master (
      output RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata,
      output RW1_en, RW1_wmode, RW1_addr, RW1_wmask, RW1_wdata,
      input  RW0_rdata, RW0_rvalid, RW1_rdata, RW1_rvalid,
      input  init_done, collision
   );

   modport slave (
      input  RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata,
      input  RW1_en, RW1_wmode, RW1_addr, RW1_wmask, RW1_wdata,
      output RW0_rdata, RW0_rvalid, RW1_rdata, RW1_rvalid,
      output init_done, collision
   );
endinterface

// File: rtl/mem_bank_2rw_mask_param.sv
// Parametrised two-port read/write memory bank with per-lane write masks.
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   reset  synchronous active-high reset; restarts the clear sweep
//   bus    mem_bank_2rw_mask_param_if.slave: two RW ports plus init_done/collision
//
// After reset the bank spends DEPTH cycles writing zeros to every entry, then
// raises init_done and serves requests. Reads are registered (1-cycle latency,
// rvalid pulse). On a same-address dual write, lanes enabled by both ports take
// port 0 data and the collision flag pulses.
//
// Optional build macro MEM_BANK_BYPASS_EN: a read that meets an opposite-port
// write to the same in-range address returns the merged (new) data instead of
// the old contents.
module mem_bank_2rw_mask_param #(
   parameter int unsigned DATA_W    = 80,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned MASK_GRAN = 8
) (
   input logic                      clk,
   input logic                      reset,
   mem_bank_2rw_mask_param_if.slave bus
);
   localparam int unsigned MASK_W = DATA_W / MASK_GRAN;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {StInit, StReady} state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  cnt_q;
   logic              init_done_q;
   logic              collision_q;
   logic [DATA_W-1:0] rdata_q [2];
   logic              rvalid_q [2];

   logic [DATA_W-1:0] mem [DEPTH];

   logic              en       [2];
   logic              wmode    [2];
   logic [ADDR_W-1:0] addr     [2];
   logic [MASK_W-1:0] wmask    [2];
   logic [DATA_W-1:0] wdata    [2];
   logic              in_range [2];
   logic [IDX_W-1:0]  idx      [2];
   logic              rd_req   [2];
   logic              wr_req   [2];
   logic [DATA_W-1:0] rd_val   [2];
   logic              accept;
   logic              same_addr;
   logic              collision_d;

   always_comb begin
      en[0]    = bus.RW0_en;
      wmode[0] = bus.RW0_wmode;
      addr[0]  = bus.RW0_addr;
      wmask[0] = bus.RW0_wmask;
      wdata[0] = bus.RW0_wdata;
      en[1]    = bus.RW1_en;
      wmode[1] = bus.RW1_wmode;
      addr[1]  = bus.RW1_addr;
      wmask[1] = bus.RW1_wmask;
      wdata[1] = bus.RW1_wdata;
   end

   always_comb begin
      // Requests are only honoured in READY and never on a reset edge.
      accept    = (state_q == StReady) && !reset;
      same_addr = (addr[0] == addr[1]);
      for (int p = 0; p < 2; p++) begin
         in_range[p] = 32'(addr[p]) < DEPTH;
         idx[p]      = addr[p][IDX_W-1:0];
         rd_req[p]   = accept && en[p] && !wmode[p];
         wr_req[p]   = accept && en[p] && wmode[p] && in_range[p];
      end
      collision_d = wr_req[0] && wr_req[1] && same_addr && ((wmask[0] & wmask[1]) != '0);
   end

`ifdef MEM_BANK_BYPASS_EN
   logic [DATA_W-1:0] fwd_bits [2];

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         fwd_bits[p] = '0;
         for (int j = 0; j < MASK_W; j++) begin
            fwd_bits[p][j*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask[p][j]}};
         end
      end
      for (int p = 0; p < 2; p++) begin
         rd_val[p] = in_range[p] ? mem[idx[p]] : '0;
         // Forward the other port's written lanes; unwritten lanes keep old data.
         if (wr_req[1-p] && same_addr && in_range[p]) begin
            rd_val[p] = (rd_val[p] & ~fwd_bits[1-p]) | (wdata[1-p] & fwd_bits[1-p]);
         end
      end
   end
`else
   always_comb begin
      // Read-first: a same-cycle write is not visible to the reader.
      for (int p = 0; p < 2; p++) begin
         rd_val[p] = in_range[p] ? mem[idx[p]] : '0;
      end
   end
`endif

   // Storage has no reset; the sweep clears it entry by entry.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == StInit)) begin
         mem[cnt_q] <= '0;
      end else begin
         for (int j = 0; j < MASK_W; j++) begin
            // Port 1 first so a port 0 write to the same lane lands last and wins.
            if (wr_req[1] && wmask[1][j]) begin
               mem[idx[1]][j*MASK_GRAN +: MASK_GRAN] <= wdata[1][j*MASK_GRAN +: MASK_GRAN];
            end
            if (wr_req[0] && wmask[0][j]) begin
               mem[idx[0]][j*MASK_GRAN +: MASK_GRAN] <= wdata[0][j*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         collision_q <= 1'b0;
         rdata_q[0]  <= '0;
         rdata_q[1]  <= '0;
         rvalid_q[0] <= 1'b0;
         rvalid_q[1] <= 1'b0;
      end else begin
         collision_q <= collision_d;
         for (int p = 0; p < 2; p++) begin
            rvalid_q[p] <= rd_req[p];
            if (rd_req[p]) begin
               rdata_q[p] <= rd_val[p];
            end
         end
         unique case (state_q)
            StInit: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == IDX_W'(DEPTH - 1)) begin
                  state_q     <= StReady;
                  init_done_q <= 1'b1;
               end
            end
            StReady: begin
               state_q <= StReady;
            end
            default: begin
               state_q <= StInit;
            end
         endcase
      end
   end

   assign bus.init_done  = init_done_q;
   assign bus.collision  = collision_q;
   assign bus.RW0_rdata  = rdata_q[0];
   assign bus.RW0_rvalid = rvalid_q[0];
   assign bus.RW1_rdata  = rdata_q[1];
   assign bus.RW1_rvalid = rvalid_q[1];
endmodule

// File: tb/tb_mem_bank_2rw_mask_param.sv
module tb_mem_bank_2rw_mask_param;
   localparam int unsigned DATA_W    = 80;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned DEPTH     = 24;
   localparam int unsigned MASK_GRAN = 8;
   localparam int unsigned MASK_W    = DATA_W / MASK_GRAN;

   typedef logic [DATA_W-1:0] word_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   mem_bank_2rw_mask_param_if #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .MASK_GRAN (MASK_GRAN)
   ) bus ();

   mem_bank_2rw_mask_param #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .MASK_GRAN (MASK_GRAN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Requested traffic for the next edge.
   logic              req_en   [2];
   logic              req_we   [2];
   logic [ADDR_W-1:0] req_addr [2];
   logic [MASK_W-1:0] req_mask [2];
   word_t             req_data [2];

   // Reference model.
   word_t model_mem [DEPTH];
   int    since_rst;
   word_t exp_rd   [2];
   logic  exp_v    [2];
   logic  exp_coll;
   logic  exp_done;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input word_t got, input word_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic word_t expand(input logic [MASK_W-1:0] m);
      word_t w = '0;
      for (int j = 0; j < MASK_W; j++) begin
         if (m[j]) w[j*MASK_GRAN +: MASK_GRAN] = '1;
      end
      return w;
   endfunction

   function automatic bit is_write(input int p);
      return req_en[p] && req_we[p] && (32'(req_addr[p]) < DEPTH);
   endfunction

   function automatic word_t model_read(input int p);
      word_t v;
      if (32'(req_addr[p]) >= DEPTH) return '0;
      v = model_mem[req_addr[p]];
`ifdef MEM_BANK_BYPASS_EN
      if (is_write(1 - p) && (req_addr[1-p] == req_addr[p])) begin
         v = (v & ~expand(req_mask[1-p])) | (req_data[1-p] & expand(req_mask[1-p]));
      end
`endif
      return v;
   endfunction

   task automatic set_req(input int p, input bit en, input bit we, input logic [ADDR_W-1:0] a,
                          input logic [MASK_W-1:0] m, input word_t d);
      req_en[p]   = en;
      req_we[p]   = we;
      req_addr[p] = a;
      req_mask[p] = m;
      req_data[p] = d;
   endtask

   function automatic word_t rnd_word();
      logic [95:0] r = {$urandom, $urandom, $urandom};
      return r[DATA_W-1:0];
   endfunction

   task automatic rnd_req(input int p);
      logic [31:0] r = $urandom;
      req_en[p]   = $urandom_range(0, 3) != 0;
      req_we[p]   = $urandom_range(0, 1) == 1;
      req_addr[p] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      req_mask[p] = ($urandom_range(0, 7) == 0) ? '0 : r[MASK_W-1:0];
      req_data[p] = rnd_word();
   endtask

   task automatic idle_req(input int p);
      rnd_req(p);
      req_en[p] = 1'b0;
   endtask

   // Apply the requests for one edge, advance the model, then check the DUT.
   task automatic step();
      bit    ready;
      word_t rd [2];
      bus.RW0_en    = req_en[0];
      bus.RW0_wmode = req_we[0];
      bus.RW0_addr  = req_addr[0];
      bus.RW0_wmask = req_mask[0];
      bus.RW0_wdata = req_data[0];
      bus.RW1_en    = req_en[1];
      bus.RW1_wmode = req_we[1];
      bus.RW1_addr  = req_addr[1];
      bus.RW1_wmask = req_mask[1];
      bus.RW1_wdata = req_data[1];

      ready = !reset && (since_rst >= DEPTH);
      if (reset) begin
         since_rst = 0;
         exp_done  = 1'b0;
         exp_coll  = 1'b0;
         exp_v[0]  = 1'b0;
         exp_v[1]  = 1'b0;
         exp_rd[0] = '0;
         exp_rd[1] = '0;
      end else begin
         exp_coll = 1'b0;
         exp_v[0] = 1'b0;
         exp_v[1] = 1'b0;
         if (ready) begin
            for (int p = 0; p < 2; p++) rd[p] = model_read(p);
            for (int p = 0; p < 2; p++) begin
               if (req_en[p] && !req_we[p]) begin
                  exp_v[p]  = 1'b1;
                  exp_rd[p] = rd[p];
               end
            end
            exp_coll = is_write(0) && is_write(1) && (req_addr[0] == req_addr[1])
                       && ((req_mask[0] & req_mask[1]) != '0);
            // Port 1 applied first, then port 0, so port 0 owns shared lanes.
            for (int p = 1; p >= 0; p--) begin
               if (is_write(p)) begin
                  model_mem[req_addr[p]] = (model_mem[req_addr[p]] & ~expand(req_mask[p]))
                                           | (req_data[p] & expand(req_mask[p]));
               end
            end
         end
         if (since_rst < DEPTH) begin
            since_rst++;
            if (since_rst == DEPTH) begin
               for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            end
         end
         exp_done = since_rst >= DEPTH;
      end

      @(posedge clk);
      #1;
      check_eq("init_done", word_t'(bus.init_done), word_t'(exp_done));
      check_eq("collision", word_t'(bus.collision), word_t'(exp_coll));
      check_eq("rvalid0", word_t'(bus.RW0_rvalid), word_t'(exp_v[0]));
      check_eq("rvalid1", word_t'(bus.RW1_rvalid), word_t'(exp_v[1]));
      check_eq("rdata0", bus.RW0_rdata, exp_rd[0]);
      check_eq("rdata1", bus.RW1_rdata, exp_rd[1]);
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i += 2) begin
         set_req(0, 1'b1, 1'b0, ADDR_W'(i), '0, '0);
         set_req(1, 1'b1, 1'b0, ADDR_W'(i + 1), '0, '0);
         step();
         check_eq("swept_zero0", bus.RW0_rdata, '0);
         check_eq("swept_zero1", bus.RW1_rdata, '0);
      end
   endtask

   task automatic random_burst(input int n);
      for (int i = 0; i < n; i++) begin
         rnd_req(0);
         rnd_req(1);
         if ($urandom_range(0, 3) == 0) req_addr[1] = req_addr[0];
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      since_rst = 0;
      idle_req(0);
      idle_req(1);

      // Reset, then the sweep with random requests that must be ignored.
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rnd_req(0);
         rnd_req(1);
         step();
         check_eq("sweep_len", word_t'(bus.init_done), word_t'(i == DEPTH - 1));
      end
      read_all();

      // Masked write then read on the other port.
      set_req(0, 1'b1, 1'b1, 5'd3, 10'b0000000101, '1);
      idle_req(1);
      step();
      idle_req(0);
      set_req(1, 1'b1, 1'b0, 5'd3, '0, '0);
      step();
      check_eq("mw_lanes", bus.RW1_rdata, 80'h00FF00FF);
      check_eq("mw_rvalid", word_t'(bus.RW1_rvalid), 1);
      idle_req(1);
      step();
      check_eq("mw_rvalid_drop", word_t'(bus.RW1_rvalid), 0);

      // Overlapping dual write: shared lane goes to port 0.
      set_req(0, 1'b1, 1'b1, 5'd7, 10'h003, {10{8'h11}});
      set_req(1, 1'b1, 1'b1, 5'd7, 10'h006, {10{8'h22}});
      step();
      check_eq("coll_pulse", word_t'(bus.collision), 1);
      set_req(0, 1'b1, 1'b0, 5'd7, '0, '0);
      idle_req(1);
      step();
      check_eq("coll_merge", bus.RW0_rdata, 80'h221111);
      check_eq("coll_drop", word_t'(bus.collision), 0);
      set_req(0, 1'b1, 1'b1, 5'd9, 10'h001, {10{8'h11}});
      set_req(1, 1'b1, 1'b1, 5'd9, 10'h002, {10{8'h22}});
      step();
      check_eq("no_coll", word_t'(bus.collision), 0);

      // Read during opposite-port write.
      set_req(0, 1'b1, 1'b1, 5'd5, '1, {10{8'hAA}});
      idle_req(1);
      step();
      set_req(0, 1'b1, 1'b1, 5'd5, 10'h001, {10{8'h55}});
      set_req(1, 1'b1, 1'b0, 5'd5, '0, '0);
      step();
`ifdef MEM_BANK_BYPASS_EN
      check_eq("rdw", bus.RW1_rdata, {{9{8'hAA}}, 8'h55});
`else
      check_eq("rdw", bus.RW1_rdata, {10{8'hAA}});
`endif
      // Dual read of the same entry.
      set_req(0, 1'b1, 1'b0, 5'd5, '0, '0);
      set_req(1, 1'b1, 1'b0, 5'd5, '0, '0);
      step();

      // Out-of-range write is dropped, out-of-range read returns 0.
      set_req(0, 1'b1, 1'b1, 5'd30, '1, '1);
      set_req(1, 1'b1, 1'b0, 5'd30, '0, '0);
      step();
      check_eq("oor_rdata", bus.RW1_rdata, '0);
      check_eq("oor_rvalid", word_t'(bus.RW1_rvalid), 1);

      random_burst(3000);

      // Reset mid-sweep restarts it; memory holds random data before the sweep.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rnd_req(0);
         rnd_req(1);
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rnd_req(0);
         rnd_req(1);
         step();
         check_eq("resweep_len", word_t'(bus.init_done), word_t'(i == DEPTH - 1));
      end
      read_all();

      random_burst(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
